// File: rtl/elevator_car_fsm_pkg.sv
// Shared types and defaults for the elevator car controller.
// State encoding and default geometry.
package elevator_car_fsm_pkg;

  localparam int NUM_FLOORS_DEF = 4;
  localparam int FLOOR_W_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVING    = 2'd1,
    ST_DOOR_OPEN = 2'd2
  } state_t;

endpackage

// File: rtl/elevator_car_fsm_tick_sync.sv
// Synchronises a slow divided clock and emits a one-cycle tick
// on each of its rising edges.
module tick_sync (
  input  logic pulse,
  input  logic reset,
  input  logic slow_clk,
  output logic tick
);

  logic meta_q;
  logic sync_q;
  logic edge_q;

  always_ff @(posedge pulse or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= slow_clk;
      sync_q <= meta_q;
      edge_q <= sync_q;
    end
  end

  assign tick = sync_q & ~edge_q;

endmodule

// File: rtl/elevator_car_fsm.sv
// Single-car elevator controller: latches calls and serves them in
// SCAN order, timing travel and door dwell in slow-clock ticks.
module elevator_car_fsm
  import elevator_car_fsm_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic                  pulse,
  input  logic                  reset,
  input  logic                  slow_clk,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_MAX =
    (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  logic tick;

  tick_sync u_tick (
    .pulse    (pulse),
    .reset    (reset),
    .slow_clk (slow_clk),
    .tick     (tick)
  );

  state_t                  state;
  state_t                  state_nx;
  logic [FLOOR_W-1:0]      floor_nx;
  logic                    dir_nx;
  logic [NUM_FLOORS-1:0]   pend_nx;
  logic [CNT_W-1:0]        move_cnt;
  logic [CNT_W-1:0]        move_nx;
  logic [CNT_W-1:0]        door_cnt;
  logic [CNT_W-1:0]        door_nx;
  logic [NUM_FLOORS-1:0]   cur_oh;
  logic [NUM_FLOORS-1:0]   above;
  logic [NUM_FLOORS-1:0]   below;
  logic [NUM_FLOORS-1:0]   clr;
  logic [NUM_FLOORS-1:0]   ignore;
  logic                    step;
  logic                    at_end;

  always_comb begin
    cur_oh = '0;
    above  = '0;
    below  = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      cur_oh[f] = (int'(current_floor) == f);
      above[f]  = pending[f] && (f > int'(current_floor));
      below[f]  = pending[f] && (f < int'(current_floor));
    end
  end

  always_comb begin
    state_nx = state;
    floor_nx = current_floor;
    dir_nx   = dir_up;
    move_nx  = move_cnt;
    door_nx  = door_cnt;
    clr      = '0;
    ignore   = '0;
    step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|(pending & cur_oh)) begin
          state_nx = ST_DOOR_OPEN;
          clr      = cur_oh;
          door_nx  = CNT_W'(DOOR_TICKS);
        end else if (|above && (dir_up || !(|below))) begin
          state_nx = ST_MOVING;
          dir_nx   = 1'b1;
          move_nx  = CNT_W'(MOVE_TICKS);
        end else if (|below) begin
          state_nx = ST_MOVING;
          dir_nx   = 1'b0;
          move_nx  = CNT_W'(MOVE_TICKS);
        end
      end
      ST_MOVING: begin
        if (tick) begin
          move_nx = move_cnt - CNT_W'(1);
          if (move_nx == '0) begin
            step     = 1'b1;
            state_nx = ST_IDLE;
            floor_nx = dir_up ? current_floor + FLOOR_W'(1)
                              : current_floor - FLOOR_W'(1);
          end
        end
      end
      ST_DOOR_OPEN: begin
        // Holding the button of the open floor must not re-arm it.
        ignore = cur_oh;
        if (tick) begin
          door_nx = door_cnt - CNT_W'(1);
          if (door_nx == '0) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    pend_nx = (pending | (call_req & ~ignore)) & ~clr;
  end

  always_ff @(posedge pulse or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      current_floor <= '0;
      dir_up        <= 1'b1;
      pending       <= '0;
      move_cnt      <= '0;
      door_cnt      <= '0;
    end else begin
      state         <= state_nx;
      current_floor <= floor_nx;
      dir_up        <= dir_nx;
      pending       <= pend_nx;
      move_cnt      <= move_nx;
      door_cnt      <= door_nx;
    end
  end

  assign moving    = (state == ST_MOVING);
  assign door_open = (state == ST_DOOR_OPEN);

  assign at_end = dir_up ? (int'(current_floor) == NUM_FLOORS - 1)
                         : (current_floor == '0);

  a_no_overrun: assert property (
    @(posedge pulse) disable iff (reset) !(step && at_end));

endmodule

// File: tb/tb_elevator_car_fsm.sv
// Bench for elevator_car_fsm: vector table, directed sequences and
// random stimulus against a behavioural model.
module tb_elevator_car_fsm;

  localparam int NF = 4;
  localparam int FW = 2;
  localparam int MT = 2;
  localparam int DT = 3;

  logic          pulse = 1'b0;
  logic          reset;
  logic          slow_clk;
  logic [NF-1:0] call_req;
  logic [FW-1:0] current_floor;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;

  int total = 0;
  int bad   = 0;

  // model: floor, direction, mode (0 idle,1 moving,2 door), ticks left
  int          m_floor;
  int          m_mode;
  int          m_left;
  bit          m_up;
  bit [NF-1:0] m_pend;
  bit          h0, h1, h2;
  int          sc = 0;

  typedef struct {
    logic [NF-1:0] call;
    logic          slow;
    logic [FW-1:0] floor;
    logic          up;
    logic          mv;
    logic          door;
    logic [NF-1:0] pend;
  } vec_t;

  vec_t tbl[14];
  int   doors[$];
  bit   prev_door;
  bit   dir_dropped;
  bit   seen;

  always #5 pulse = ~pulse;

  elevator_car_fsm #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .MOVE_TICKS (MT),
    .DOOR_TICKS (DT)
  ) dut (
    .pulse         (pulse),
    .reset         (reset),
    .slow_clk      (slow_clk),
    .call_req      (call_req),
    .current_floor (current_floor),
    .dir_up        (dir_up),
    .moving        (moving),
    .door_open     (door_open),
    .pending       (pending)
  );

  function automatic logic [8:0] got();
    return {current_floor, dir_up, moving, door_open, pending};
  endfunction

  function automatic logic [8:0] want();
    logic [FW-1:0] f;
    f = m_floor[FW-1:0];
    return {f, m_up, m_mode == 1, m_mode == 2, m_pend};
  endfunction

  task automatic check(input string nm, input logic [8:0] exp);
    total++;
    if (got() !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got(), exp, $time);
    end
  endtask

  task automatic model_reset();
    m_floor = 0;
    m_mode  = 0;
    m_left  = 0;
    m_up    = 1'b1;
    m_pend  = '0;
    h0 = 0;
    h1 = 0;
    h2 = 0;
  endtask

  // State after the coming clock edge, given the inputs now applied.
  task automatic model_edge();
    bit          tk;
    bit [NF-1:0] np;
    bit          any_up, any_dn;
    if (reset) begin
      model_reset();
      return;
    end
    tk = h1 & ~h2;
    np = m_pend | call_req;
    if (m_mode == 2) np[m_floor] = m_pend[m_floor];
    any_up = 0;
    any_dn = 0;
    for (int f = 0; f < NF; f++) begin
      if (m_pend[f] && f > m_floor) any_up = 1;
      if (m_pend[f] && f < m_floor) any_dn = 1;
    end
    if (m_mode == 0) begin
      if (m_pend[m_floor]) begin
        m_mode = 2;
        m_left = DT;
        np[m_floor] = 1'b0;
      end else if (any_up && (m_up || !any_dn)) begin
        m_mode = 1;
        m_up   = 1;
        m_left = MT;
      end else if (any_dn) begin
        m_mode = 1;
        m_up   = 0;
        m_left = MT;
      end
    end else if (tk) begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == 1) m_floor += m_up ? 1 : -1;
        m_mode = 0;
      end
    end
    m_pend = np;
    h2 = h1;
    h1 = h0;
    h0 = slow_clk;
  endtask

  task automatic step(input string nm);
    model_edge();
    @(posedge pulse);
    @(negedge pulse);
    check(nm, want());
    if (door_open && !prev_door) doors.push_back(int'(current_floor));
    prev_door = door_open;
    if (!dir_up) dir_dropped = 1;
  endtask

  task automatic auto_slow();
    sc++;
    if (sc >= 3) begin
      sc = 0;
      slow_clk = ~slow_clk;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    slow_clk = 1'b0;
    call_req = '0;
    sc       = 0;
    step("reset");
    reset = 1'b0;
    doors.delete();
    prev_door   = 0;
    dir_dropped = 0;
  endtask

  task automatic wait_for(input int fl, input int md, input string nm);
    int i;
    for (i = 0; i < 400 && !(m_floor == fl && m_mode == md); i++) begin
      auto_slow();
      step(nm);
    end
    total++;
    if (!(m_floor == fl && m_mode == md)) begin
      bad++;
      $display("FAIL %s: timeout, model floor %0d mode %0d", nm,
               m_floor, m_mode);
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0001};
    tbl[1]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[2]  = '{4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[3]  = '{4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[4]  = '{4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[5]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[6]  = '{4'b0100, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[7]  = '{4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[8]  = '{4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[9]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[10] = '{4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[11] = '{4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[12] = '{4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0100};
    tbl[13] = '{4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0100};

    reset    = 1'b1;
    slow_clk = 1'b1;
    call_req = '0;
    model_reset();

    // reset held with live inputs, released with slow_clk already high
    for (int i = 0; i < 4; i++) begin
      call_req = NF'($urandom_range(0, 15));
      step("reset_hold");
    end
    reset    = 1'b0;
    call_req = 4'b0110;
    step("release_latch");
    call_req = '0;
    for (int i = 0; i < 6; i++) step("release_run");

    // single-floor door cycle from the vector table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      call_req = tbl[i].call;
      slow_clk = tbl[i].slow;
      model_edge();
      @(posedge pulse);
      @(negedge pulse);
      check($sformatf("vec%0d", i),
            {tbl[i].floor, tbl[i].up, tbl[i].mv, tbl[i].door,
             tbl[i].pend});
    end

    // calls on 3 and 1 together: stop at 1 then 3, never turning down
    do_reset();
    call_req = 4'b1010;
    step("scan_up");
    call_req = '0;
    for (int i = 0; i < 300; i++) begin
      auto_slow();
      step("scan_up");
    end
    total++;
    if (doors.size() != 2 || doors[0] != 1 || doors[1] != 3
        || dir_dropped) begin
      bad++;
      $display("FAIL scan_up_order: doors %p dir_dropped %0d want '{1,3} 0",
               doors, dir_dropped);
    end

    // reach floor 2 heading up with {3,0} pending; hold button 3 at 3
    do_reset();
    call_req = 4'b0100;
    step("turn");
    call_req = '0;
    wait_for(1, 1, "turn_reach1");
    call_req = 4'b1001;
    auto_slow();
    step("turn");
    call_req = '0;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      auto_slow();
      call_req[3] = (m_mode == 2 && m_floor == 3);
      step("turn");
      if (door_open && current_floor == 2'd3 && !seen) begin
        seen = 1;
        total++;
        if (pending[3] !== 1'b0) begin
          bad++;
          $display("FAIL hold_call3: pending[3] %b want 0", pending[3]);
        end
      end
    end
    total++;
    if (doors.size() != 3 || doors[0] != 2 || doors[1] != 3
        || doors[2] != 0 || dir_up !== 1'b0) begin
      bad++;
      $display("FAIL turn_order: doors %p dir %b want '{2,3,0} 0",
               doors, dir_up);
    end

    // asynchronous reset while travelling from 1 to 2
    do_reset();
    call_req = 4'b0100;
    step("async");
    call_req = '0;
    wait_for(1, 1, "async_reach1");
    #2 reset = 1'b1;
    #1 check("async_reset", {2'b00, 1'b1, 1'b0, 1'b0, 4'b0000});
    model_reset();
    for (int i = 0; i < 20; i++) begin
      slow_clk = ~slow_clk;
      call_req = NF'($urandom_range(0, 15));
      step("reset_slow");
    end
    reset    = 1'b0;
    call_req = '0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) slow_clk = ~slow_clk;
      call_req = ($urandom_range(0, 9) == 0) ?
                 NF'($urandom_range(0, 15)) : '0;
      reset = ($urandom_range(0, 999) == 0);
      step("random");
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
